gba_backup_sd: RTL and testbench
================================

GBA_BACKUP_SD -- requirements
Module: gba_backup_sd

Interface
REQ-001 Parameter SAVE_BASE, default 24'd8454144, is the dword address in SDRAM of save byte 0 (the flash region).
REQ-002 Port clk_sys, input, 1: the system clock; every register changes on its rising edge.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port bk_ena, input, 1: save backup is enabled; while 0, start requests are ignored.
REQ-005 Port bk_load, input, 1: level input; a rising edge requests a load from SD.
REQ-006 Port bk_save, input, 1: level input; a rising edge requests a save to SD.
REQ-007 Port last_sector, input, 8: index of the final 512-byte sector; it is sampled when an operation starts.
REQ-008 Port busy, output, 1: an operation is in progress.
REQ-009 Port loading, output, 1: the current operation is a load.
REQ-010 Port sd_lba, output, 32: the current sector number.
REQ-011 Ports sd_rd and sd_wr, outputs, 1 each: sector read and write requests to hps_io.
REQ-012 Port sd_ack, input, 1: hps_io transfer acknowledge.
REQ-013 Ports sd_buff_addr (input, 8), sd_buff_dout (input, 16), sd_buff_wr (input, 1) and sd_buff_din (output, 16): the sector word stream.
REQ-014 Ports mem_addr (output, 24, dword address), mem_din (output, 32), mem_dout (input, 32), mem_req (output, 1), mem_rnw (output, 1) and mem_ack (input, 1): the SDRAM ch2 port.

Function
REQ-015 The block SHALL contain a 256x16 sector buffer, viewed as 128 dwords: word 2k maps to dword k bits [15:0], word 2k+1 maps to dword k bits [31:16].
REQ-016 On sd_buff_wr, buffer[sd_buff_addr] SHALL be written with sd_buff_dout.
REQ-017 sd_buff_din SHALL be a registered read of buffer[sd_buff_addr], valid one clock after sd_buff_addr changes.
REQ-018 The FSM states SHALL be IDLE, FILL, SD_REQ, SD_XFER and DRAIN.
REQ-019 In IDLE, a load SHALL start on a rising edge of bk_load while bk_ena=1: latch last_sector, set sd_lba=0, set loading=1, go to SD_REQ.
REQ-020 In IDLE, a save SHALL start on a rising edge of bk_save while bk_ena=1: latch last_sector, set sd_lba=0, set loading=0, go to FILL.
REQ-021 If both edges occur in the same cycle, the load SHALL win and the save edge SHALL be discarded.
REQ-022 Edges outside IDLE SHALL be discarded, not queued.
REQ-023 Edge detectors SHALL be per-input registers of the previous level.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 SD_REQ: assert sd_rd=loading and sd_wr=~loading; on the rising edge of sd_ack, clear both and go to SD_XFER.
REQ-026 SD_XFER: on the falling edge of sd_ack, a load SHALL go to DRAIN.
REQ-027 SD_XFER: on the falling edge of sd_ack, a save SHALL go to IDLE if sd_lba equals the latched last_sector; otherwise it SHALL increment sd_lba and go to FILL.
REQ-028 FILL: for k = 0..127, the block SHALL issue one read at mem_addr = SAVE_BASE + sd_lba*128 + k and store mem_dout into dword k on mem_ack; after k = 127 completes, go to SD_REQ.
REQ-029 DRAIN: for k = 0..127, the block SHALL issue one write of dword k (mem_din) to the same address formula; after k = 127 is acked, go to IDLE if sd_lba equals last_sector, else increment sd_lba and go to SD_REQ.
REQ-030 mem_req SHALL be a one-cycle pulse, with at most one request outstanding.
REQ-031 The next mem_req SHALL be issued no earlier than the cycle after mem_ack.
REQ-032 mem_addr, mem_din and mem_rnw SHALL be held stable from mem_req until mem_ack.
REQ-033 mem_rnw SHALL be 1 in FILL and 0 in DRAIN.
REQ-034 Address arithmetic SHALL be 24-bit and wrap modulo 2^24.
REQ-035 sd_lba SHALL never exceed the latched last_sector.
REQ-036 If bk_ena falls mid-operation, the operation SHALL complete normally.
REQ-037 sd_ack high while in IDLE or FILL SHALL be ignored.
REQ-038 In SD_REQ, a rising edge of sd_ack is detected against the registered previous level; if sd_ack is already high on entry, the FSM SHALL wait for it to fall and rise again.

Reset
REQ-039 When reset_n=0, the block SHALL asynchronously set state=IDLE and sd_lba=0.
REQ-040 When reset_n=0, the block SHALL set busy, loading, sd_rd, sd_wr, mem_req, mem_rnw and sd_buff_din to 0, and mem_addr and mem_din to 0.
REQ-041 When reset_n=0, the edge-detector registers SHALL be cleared.
REQ-042 A reset mid-operation SHALL abort it with no further mem_req, sd_rd or sd_wr.
REQ-043 The buffer contents need not be reset.

Verification
REQ-044 Load test: last_sector=1, bk_ena=1, pulse bk_load; the SD model writes words 0x0000..0x00FF, then 0x0100..0x01FF. Required: sd_rd is asserted for lba 0 then lba 1; 256 writes occur; the write to 0x810000 carries 0x00010000 and the write to 0x8100FF carries 0x01FF01FE; busy falls after the last ack.
REQ-045 Save test: last_sector=0; memory holds dword k = 0xA5000000+k; pulse bk_save. Required: 128 reads, then sd_wr; sd_buff_addr=3 gives sd_buff_din=0xA500 one clock later, and sd_buff_addr=2 gives 0x0001.
REQ-046 Simultaneous test: bk_load and bk_save rise in the same cycle. Required: loading=1 and sd_rd=1; no save follows.
REQ-047 Ignore test: bk_ena=0 with a bk_save edge, then a bk_load edge while busy. Required: no start in the first case; the second edge has no effect on the running operation.
REQ-048 Reset test: assert reset_n=0 during DRAIN at k=40. Required: all outputs are 0 immediately, and no mem_req occurs until a new bk_load edge.
REQ-049 Stall test: mem_ack is delayed a random 1..20 cycles. Required: mem_req is never re-pulsed before its ack, and the address and data are stable throughout.

Source files
------------

// File: rtl/gba_backup_sd.sv
// rtl/gba_backup_sd.sv - moves the GBA save region between SDRAM and SD sectors
// through a one-sector buffer.
module gba_backup_sd #(
    parameter logic [23:0] SAVE_BASE = 24'd8454144
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        bk_ena,
    input  logic        bk_load,
    input  logic        bk_save,
    input  logic [7:0]  last_sector,
    output logic        busy,
    output logic        loading,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [15:0] sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [15:0] sd_buff_din,
    output logic [23:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        mem_req,
    output logic        mem_rnw,
    input  logic        mem_ack
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL    = 3'd1;
    localparam logic [2:0] S_SD_REQ  = 3'd2;
    localparam logic [2:0] S_SD_XFER = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic [2:0]  r_state;
    logic [7:0]  r_lba;
    logic [7:0]  r_last;
    logic        r_loading;
    logic        r_sd_rd;
    logic        r_sd_wr;
    logic        r_load_d;
    logic        r_save_d;
    logic        r_ack_d;
    logic [6:0]  r_k;
    logic        r_pending;
    logic        r_mem_req;
    logic        r_mem_rnw;
    logic [23:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic [15:0] r_buff_din;

    // Sector buffer split into low/high halves so a whole dword moves per access.
    logic [15:0] r_buf_lo [0:127];
    logic [15:0] r_buf_hi [0:127];

    logic        w_load_rise;
    logic        w_save_rise;
    logic        w_ack_rise;
    logic        w_ack_fall;
    logic        w_at_last;
    logic        w_fill_wr;
    logic [23:0] w_mem_addr;

    assign w_load_rise = bk_load & ~r_load_d;
    assign w_save_rise = bk_save & ~r_save_d;
    assign w_ack_rise  = sd_ack & ~r_ack_d;
    assign w_ack_fall  = ~sd_ack & r_ack_d;
    assign w_at_last   = (r_lba == r_last);
    assign w_fill_wr   = (r_state == S_FILL) && r_pending && mem_ack;
    assign w_mem_addr  = SAVE_BASE + {9'd0, r_lba, 7'd0} + {17'd0, r_k};

    assign busy         = (r_state != S_IDLE);
    assign loading      = r_loading;
    assign sd_lba       = {24'd0, r_lba};
    assign sd_rd        = r_sd_rd;
    assign sd_wr        = r_sd_wr;
    assign sd_buff_din  = r_buff_din;
    assign mem_addr     = r_mem_addr;
    assign mem_din      = r_mem_din;
    assign mem_req      = r_mem_req;
    assign mem_rnw      = r_mem_rnw;

    always_ff @(posedge clk_sys) begin
        if (w_fill_wr) begin
            r_buf_lo[r_k] <= mem_dout[15:0];
            r_buf_hi[r_k] <= mem_dout[31:16];
        end else if (sd_buff_wr) begin
            if (sd_buff_addr[0]) begin
                r_buf_hi[sd_buff_addr[7:1]] <= sd_buff_dout;
            end else begin
                r_buf_lo[sd_buff_addr[7:1]] <= sd_buff_dout;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_buff_din <= 16'd0;
        end else begin
            r_buff_din <= sd_buff_addr[0] ? r_buf_hi[sd_buff_addr[7:1]]
                                          : r_buf_lo[sd_buff_addr[7:1]];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_lba      <= 8'd0;
            r_last     <= 8'd0;
            r_loading  <= 1'b0;
            r_sd_rd    <= 1'b0;
            r_sd_wr    <= 1'b0;
            r_load_d   <= 1'b0;
            r_save_d   <= 1'b0;
            r_ack_d    <= 1'b0;
            r_k        <= 7'd0;
            r_pending  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_rnw  <= 1'b0;
            r_mem_addr <= 24'd0;
            r_mem_din  <= 32'd0;
        end else begin
            r_load_d  <= bk_load;
            r_save_d  <= bk_save;
            r_ack_d   <= sd_ack;
            r_mem_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Load wins a same-cycle tie; the save edge is simply dropped.
                    if (bk_ena && w_load_rise) begin
                        r_last    <= last_sector;
                        r_lba     <= 8'd0;
                        r_loading <= 1'b1;
                        r_k       <= 7'd0;
                        r_state   <= S_SD_REQ;
                    end else if (bk_ena && w_save_rise) begin
                        r_last    <= last_sector;
                        r_lba     <= 8'd0;
                        r_loading <= 1'b0;
                        r_k       <= 7'd0;
                        r_pending <= 1'b0;
                        r_state   <= S_FILL;
                    end
                end
                S_SD_REQ: begin
                    if (w_ack_rise) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= S_SD_XFER;
                    end else begin
                        r_sd_rd <= r_loading;
                        r_sd_wr <= ~r_loading;
                    end
                end
                S_SD_XFER: begin
                    if (w_ack_fall) begin
                        r_k <= 7'd0;
                        if (r_loading) begin
                            r_state <= S_DRAIN;
                        end else if (w_at_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_lba   <= r_lba + 8'd1;
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL, S_DRAIN: begin
                    if (!r_pending) begin
                        r_mem_req  <= 1'b1;
                        r_pending  <= 1'b1;
                        r_mem_addr <= w_mem_addr;
                        r_mem_rnw  <= (r_state == S_FILL);
                        if (r_state == S_DRAIN) begin
                            r_mem_din <= {r_buf_hi[r_k], r_buf_lo[r_k]};
                        end
                    end else if (mem_ack) begin
                        r_pending <= 1'b0;
                        if (r_k == 7'd127) begin
                            if (r_state == S_FILL) begin
                                r_state <= S_SD_REQ;
                            end else if (w_at_last) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_lba   <= r_lba + 8'd1;
                                r_state <= S_SD_REQ;
                            end
                        end else begin
                            r_k <= r_k + 7'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gba_backup_sd.sv
// tb/tb_gba_backup_sd.sv - bench for gba_backup_sd with SD card and SDRAM models
// and a transaction scoreboard.
module tb_gba_backup_sd;

    localparam logic [23:0] BASE = 24'h810000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        bk_ena = 1'b0;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic [7:0]  last_sector = 8'd0;
    logic        busy;
    logic        loading;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack = 1'b0;
    logic [7:0]  sd_buff_addr = 8'd0;
    logic [15:0] sd_buff_dout = 16'd0;
    logic        sd_buff_wr = 1'b0;
    logic [15:0] sd_buff_din;
    logic [23:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'd0;
    logic        mem_req;
    logic        mem_rnw;
    logic        mem_ack = 1'b0;

    gba_backup_sd dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .bk_ena(bk_ena),
        .bk_load(bk_load), .bk_save(bk_save), .last_sector(last_sector),
        .busy(busy), .loading(loading), .sd_lba(sd_lba),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_ack(mem_ack)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [23:0] addr;
        logic        rnw;
        logic [31:0] data;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    txn_t        exp_q[$];
    bit          exp_load;
    int          exp_last;
    int          exp_sector;
    int          sd_sec;
    bit          sd_save_xfer = 1'b0;
    bit          sd_is_rd;
    logic [31:0] mem [int];
    bit          seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    function automatic logic [15:0] sd_word(input int s, input int a);
        return 16'(s * 256 + a);
    endfunction

    // Buffer word the DUT must present during a save, derived from SDRAM contents.
    function automatic logic [15:0] save_word(input int s, input logic [7:0] a);
        logic [31:0] d;
        d = mem_rd(int'(BASE) + s * 128 + int'(a[7:1]));
        return a[0] ? d[31:16] : d[15:0];
    endfunction

    task automatic expect_op(input bit ld, input int last);
        txn_t t;
        exp_q.delete();
        exp_load   = ld;
        exp_last   = last;
        exp_sector = 0;
        sd_sec     = 0;
        for (int s = 0; s <= last; s++) begin
            for (int k = 0; k < 128; k++) begin
                t.addr = BASE + 24'(s * 128 + k);
                t.rnw  = !ld;
                t.data = {sd_word(s, 2 * k + 1), sd_word(s, 2 * k)};
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse(input bit ld, input bit sv);
        @(posedge clk_sys);
        #1;
        bk_load = ld;
        bk_save = sv;
        tick(1);
        bk_load = 1'b0;
        bk_save = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy && c < 20000) begin
            @(negedge clk_sys);
            c++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    // SDRAM: random 1..20 cycle latency, single outstanding request.
    initial begin : sdram
        int          cnt;
        bit          act;
        logic [23:0] a;
        logic        r;
        logic [31:0] d;
        act = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_ack = 1'b0;
            if (!reset_n) begin
                act = 1'b0;
            end else if (act) begin
                cnt--;
                if (cnt == 0) begin
                    act     = 1'b0;
                    mem_ack = 1'b1;
                    if (r) mem_dout = mem_rd(int'(a));
                    else   mem[int'(a)] = d;
                end
            end else if (mem_req) begin
                act = 1'b1;
                cnt = int'($urandom_range(1, 20));
                a   = mem_addr;
                r   = mem_rnw;
                d   = mem_din;
            end
        end
    end

    // SD card: ack, stream 256 words in or out, drop ack.
    initial begin : sdcard
        forever begin
            @(posedge clk_sys);
            #1;
            if (reset_n && (sd_rd || sd_wr)) begin
                sd_is_rd = sd_rd;
                repeat (2) @(posedge clk_sys);
                #1;
                sd_ack = 1'b1;
                tick(1);
                for (int a = 0; a < 256; a++) begin
                    sd_buff_addr = 8'(a);
                    if (sd_is_rd) begin
                        sd_buff_dout = sd_word(sd_sec, a);
                        sd_buff_wr   = 1'b1;
                    end else begin
                        sd_save_xfer = 1'b1;
                    end
                    tick(1);
                end
                sd_buff_wr   = 1'b0;
                sd_save_xfer = 1'b0;
                tick(1);
                sd_ack = 1'b0;
                sd_sec++;
            end
        end
    end

    initial begin : compare
        bit          outst;
        logic [23:0] la;
        logic [31:0] ld;
        logic        lr;
        bit          prev_any;
        bit          prev_sx;
        logic [7:0]  prev_addr;
        txn_t        t;
        outst = 1'b0; prev_any = 1'b0; prev_sx = 1'b0; prev_addr = 8'd0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                outst = 1'b0; prev_any = 1'b0; prev_sx = 1'b0;
                continue;
            end
            if (mem_req) begin
                chk("mem_req_while_outstanding", {63'd0, outst}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_mem_req", {40'd0, mem_addr}, 64'hFFFFFFFF);
                end else begin
                    t = exp_q.pop_front();
                    chk("mem_addr", {40'd0, mem_addr}, {40'd0, t.addr});
                    chk("mem_rnw", {63'd0, mem_rnw}, {63'd0, t.rnw});
                    if (!t.rnw) chk("mem_din", {32'd0, mem_din}, {32'd0, t.data});
                end
                outst = 1'b1; la = mem_addr; ld = mem_din; lr = mem_rnw;
            end else if (outst) begin
                chk("mem_stable", {7'd0, mem_addr, mem_din, lr == mem_rnw},
                    {7'd0, la, ld, 1'b1});
            end
            if (mem_ack) outst = 1'b0;
            chk("rd_wr_exclusive", {63'd0, sd_rd & sd_wr}, 64'd0);
            if ((sd_rd || sd_wr) && !prev_any) begin
                chk("sd_req_is_rd", {63'd0, sd_rd}, {63'd0, exp_load});
                chk("sd_req_lba", {32'd0, sd_lba}, 64'(exp_sector));
                chk("sd_req_mem_left", 64'(exp_q.size()),
                    64'(exp_load ? (exp_last - exp_sector + 1) * 128
                                 : (exp_last - exp_sector) * 128));
                exp_sector++;
            end
            if (busy) chk("lba_le_last", {63'd0, sd_lba <= 32'(exp_last)}, 64'd1);
            if (prev_sx) chk("sd_buff_din", {48'd0, sd_buff_din},
                             {48'd0, save_word(sd_sec, prev_addr)});
            prev_any  = sd_rd | sd_wr;
            prev_sx   = sd_save_xfer;
            prev_addr = sd_buff_addr;
        end
    end

    initial begin : main
        int c;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_loading", {63'd0, loading}, 64'd0);
        chk("rst_sd_rdwr", {62'd0, sd_rd, sd_wr}, 64'd0);
        chk("rst_mem_req_rnw", {62'd0, mem_req, mem_rnw}, 64'd0);
        chk("rst_addr_din", {8'd0, mem_addr, mem_din}, 64'd0);
        chk("rst_lba_buff", {16'd0, sd_lba, sd_buff_din}, 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Load of two sectors
        bk_ena = 1'b1;
        last_sector = 8'd1;
        expect_op(1'b1, 1);
        pulse(1'b1, 1'b0);
        tick(2);
        chk("load_busy", {62'd0, busy, loading}, 64'd3);
        wait_idle("load_done");
        chk("load_all_writes", 64'(exp_q.size()), 64'd0);
        chk("load_sectors", 64'(exp_sector), 64'd2);
        chk("load_lit_810000", {32'd0, mem_rd(32'h810000)}, 64'h00010000);
        chk("load_lit_8100FF", {32'd0, mem_rd(32'h8100FF)}, 64'h01FF01FE);

        // Save of one sector
        for (int k = 0; k < 128; k++) mem[int'(BASE) + k] = 32'hA5000000 + 32'(k);
        last_sector = 8'd0;
        expect_op(1'b0, 0);
        pulse(1'b0, 1'b1);
        tick(2);
        chk("save_busy", {62'd0, busy, loading}, 64'd2);
        wait_idle("save_done");
        chk("save_all_reads", 64'(exp_q.size()), 64'd0);
        chk("save_sectors", 64'(exp_sector), 64'd1);
        sd_buff_addr = 8'd3;
        tick(1);
        chk("save_lit_addr3", {48'd0, sd_buff_din}, 64'hA500);
        sd_buff_addr = 8'd2;
        tick(1);
        chk("save_lit_addr2", {48'd0, sd_buff_din}, 64'h0001);

        // Simultaneous edges: load wins
        expect_op(1'b1, 0);
        pulse(1'b1, 1'b1);
        tick(2);
        chk("simul_loading", {62'd0, busy, loading}, 64'd3);
        c = 0;
        while (!sd_rd && c < 20) begin tick(1); c++; end
        chk("simul_sd_rd", {63'd0, sd_rd}, 64'd1);
        wait_idle("simul_done");
        chk("simul_all_writes", 64'(exp_q.size()), 64'd0);
        tick(20);
        chk("simul_no_save", {63'd0, busy}, 64'd0);

        // Disabled start, then a load edge and bk_ena drop during a save
        bk_ena = 1'b0;
        pulse(1'b0, 1'b1);
        tick(10);
        chk("ignore_disabled", {63'd0, busy}, 64'd0);
        bk_ena = 1'b1;
        expect_op(1'b0, 0);
        pulse(1'b0, 1'b1);
        tick(5);
        bk_ena = 1'b0;
        pulse(1'b1, 1'b0);
        tick(2);
        chk("ignore_busy_edge", {62'd0, busy, loading}, 64'd2);
        wait_idle("ignore_done");
        chk("ignore_all_reads", 64'(exp_q.size()), 64'd0);
        tick(10);
        chk("ignore_no_load", {63'd0, busy}, 64'd0);

        // Reset in the middle of DRAIN
        bk_ena = 1'b1;
        expect_op(1'b1, 0);
        pulse(1'b1, 1'b0);
        c = 0;
        while (exp_q.size() > 88 && c < 10000) begin @(negedge clk_sys); c++; end
        chk("reset_reached_k40", {63'd0, exp_q.size() <= 88}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_ctrl", {58'd0, busy, loading, sd_rd, sd_wr, mem_req, mem_rnw}, 64'd0);
        chk("abort_addr_din", {8'd0, mem_addr, mem_din}, 64'd0);
        chk("abort_lba_buff", {16'd0, sd_lba, sd_buff_din}, 64'd0);
        exp_q.delete();
        tick(3);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_sys);
            if (mem_req || sd_rd || sd_wr || busy) seen = 1'b1;
        end
        chk("abort_quiet", {63'd0, seen}, 64'd0);
        expect_op(1'b1, 0);
        pulse(1'b1, 1'b0);
        tick(2);
        chk("restart_busy", {63'd0, busy}, 64'd1);
        wait_idle("restart_done");
        chk("restart_all_writes", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
